// File: rtl/div2d_pkg.sv
// Shared definitions for the divergence block: default geometry, FSM state
// encodings common with the gradient block, and a small sizing helper.
package div2d_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_ADD_W = 12;
   localparam int DEF_ROWS  = 64;
   localparam int DEF_COLS  = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Number of pixels in one frame.
   function automatic int sample_count(input int rows, input int cols);
      return rows * cols;
   endfunction

endpackage

// File: rtl/div2d_if.sv
// Bus bundle between the divergence block and its environment: start pulse,
// px/py memory read port and divergence output stream.
interface div2d_if
   import div2d_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ADD_W = DEF_ADD_W
);
   logic                      i_start;
   logic signed [WIDTH-1:0]   i_datax;
   logic signed [WIDTH-1:0]   i_datay;
   logic        [ADD_W-1:0]   o_rd_addr;
   logic signed [WIDTH+1:0]   o_data;
   logic        [ADD_W-1:0]   o_wr_addr;
   logic                      o_valid;
   logic                      o_busy;

   modport slave (
      input  i_start, i_datax, i_datay,
      output o_rd_addr, o_data, o_wr_addr, o_valid, o_busy
   );

   modport master (
      output i_start, i_datax, i_datay,
      input  o_rd_addr, o_data, o_wr_addr, o_valid, o_busy
   );
endinterface

// File: rtl/div2d_line_buffer.sv
// Circular delay line: each write returns the sample written DEPTH writes
// earlier. Storage is not reset; only the pointer is.
module div2d_line_buffer
   import div2d_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_COLS
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    ptr_r;

   // Old content at the pointer is the sample from one line ago.
   assign dout = mem_r[ptr_r];

   // Overwrite the slot just read with the new sample.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[ptr_r] <= din;
      end
   end

   // Advance the circular pointer on every write.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (wr_en) begin
         if (ptr_r == PTR_LAST) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= ptr_r + PTR_ONE;
         end
      end
   end
endmodule

// File: rtl/div2d.sv
// Discrete divergence (adjoint of forward-difference gradient). Streams px/py
// in raster order, one pixel per clock, and emits Dx^T px + Dy^T py two cycles
// after each read address.
module div2d
   import div2d_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ADD_W = DEF_ADD_W,
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS
)(
   input  logic  i_clk,
   input  logic  i_reset,
   div2d_if.slave bus
);
   localparam int NPIX = sample_count(ROWS, COLS);
   localparam int RW   = $clog2(ROWS);
   localparam int CW   = $clog2(COLS);
   localparam logic [ADD_W-1:0] LAST_ADDR = ADD_W'(NPIX - 1);
   localparam logic [ADD_W-1:0] ADDR_ONE  = ADD_W'(1);
   localparam logic [CW-1:0]    LAST_COL  = CW'(COLS - 1);
   localparam logic [CW-1:0]    COL_ONE   = CW'(1);
   localparam logic [RW-1:0]    LAST_ROW  = RW'(ROWS - 1);
   localparam logic [RW-1:0]    ROW_ONE   = RW'(1);

   state_t             state_r, state_s;
   logic               drain_r;
   logic               busy_r;
   logic [ADD_W-1:0]   rd_addr_r;
   logic [RW-1:0]      row_r;
   logic [CW-1:0]      col_r;

   // Stage 1: position of the sample currently returned by memory.
   logic               v1_r;
   logic [RW-1:0]      row1_r;
   logic [CW-1:0]      col1_r;
   logic [ADD_W-1:0]   addr1_r;

   logic signed [WIDTH-1:0] px_prev_r;
   logic        [WIDTH-1:0] py_up_s;
   logic signed [WIDTH+1:0] px_e_s, pxp_e_s, py_e_s, pyu_e_s, dx_s, dy_s;

   logic               valid_r;
   logic signed [WIDTH+1:0] data_r;
   logic [ADD_W-1:0]   wr_addr_r;

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state: start only honoured in IDLE; two drain cycles flush the pipeline.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.i_start) state_s = ST_RUN;
            else             state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (rd_addr_r == LAST_ADDR) state_s = ST_DRAIN;
            else                        state_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (drain_r) state_s = ST_IDLE;
            else         state_s = ST_DRAIN;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Busy flag and drain cycle counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         busy_r  <= 1'b0;
         drain_r <= 1'b0;
      end else begin
         busy_r  <= (state_s != ST_IDLE);
         drain_r <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
      end
   end

   // Read address and raster row/column counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rd_addr_r <= '0;
         row_r     <= '0;
         col_r     <= '0;
      end else if (state_r == ST_RUN && rd_addr_r != LAST_ADDR) begin
         rd_addr_r <= rd_addr_r + ADDR_ONE;
         if (col_r == LAST_COL) begin
            col_r <= '0;
            row_r <= row_r + ROW_ONE;
         end else begin
            col_r <= col_r + COL_ONE;
         end
      end else begin
         rd_addr_r <= '0;
         row_r     <= '0;
         col_r     <= '0;
      end
   end

   // Align position with the one-cycle memory read latency.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         v1_r    <= 1'b0;
         row1_r  <= '0;
         col1_r  <= '0;
         addr1_r <= '0;
      end else begin
         v1_r    <= (state_r == ST_RUN);
         row1_r  <= row_r;
         col1_r  <= col_r;
         addr1_r <= rd_addr_r;
      end
   end

   // Left neighbour px[i,j-1]; stale at j==0 but never used there.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         px_prev_r <= '0;
      end else if (v1_r) begin
         px_prev_r <= bus.i_datax;
      end
   end

   div2d_line_buffer #(.WIDTH(WIDTH), .DEPTH(COLS)) u_line (
      .clk   (i_clk),
      .reset (i_reset),
      .wr_en (v1_r),
      .din   (bus.i_datay),
      .dout  (py_up_s)
   );

   // Backward differences with the adjoint boundary rules at first/last column and row.
   always_comb begin
      px_e_s  = {{2{bus.i_datax[WIDTH-1]}}, bus.i_datax};
      pxp_e_s = {{2{px_prev_r[WIDTH-1]}}, px_prev_r};
      py_e_s  = {{2{bus.i_datay[WIDTH-1]}}, bus.i_datay};
      pyu_e_s = {{2{py_up_s[WIDTH-1]}}, py_up_s};
      if (col1_r == '0) begin
         dx_s = px_e_s;
      end else if (col1_r == LAST_COL) begin
         dx_s = -pxp_e_s;
      end else begin
         dx_s = px_e_s - pxp_e_s;
      end
      if (row1_r == '0) begin
         dy_s = py_e_s;
      end else if (row1_r == LAST_ROW) begin
         dy_s = -pyu_e_s;
      end else begin
         dy_s = py_e_s - pyu_e_s;
      end
   end

   // Registered output sample and its raster address.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         valid_r   <= 1'b0;
         data_r    <= '0;
         wr_addr_r <= '0;
      end else if (v1_r) begin
         valid_r   <= 1'b1;
         data_r    <= dx_s + dy_s;
         wr_addr_r <= addr1_r;
      end else begin
         valid_r   <= 1'b0;
         data_r    <= '0;
         wr_addr_r <= '0;
      end
   end

   assign bus.o_rd_addr = rd_addr_r;
   assign bus.o_data    = data_r;
   assign bus.o_wr_addr = wr_addr_r;
   assign bus.o_valid   = valid_r;
   assign bus.o_busy    = busy_r;
endmodule

// File: tb/tb_div2d.sv
// Self-checking bench for div2d on a 4x4 image with 8-bit samples.
module tb_div2d;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int WIDTH = 8;
   localparam int ADD_W = 4;
   localparam int NPIX  = ROWS * COLS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   logic signed [WIDTH-1:0] px_mem [NPIX];
   logic signed [WIDTH-1:0] py_mem [NPIX];
   int got [NPIX];

   div2d_if #(.WIDTH(WIDTH), .ADD_W(ADD_W)) bus ();

   div2d #(.WIDTH(WIDTH), .ADD_W(ADD_W), .ROWS(ROWS), .COLS(COLS)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // One-cycle synchronous ROM for px and py.
   always @(posedge clk) begin
      bus.i_datax <= px_mem[bus.o_rd_addr];
      bus.i_datay <= py_mem[bus.o_rd_addr];
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference divergence from the definition of the adjoint differences.
   function automatic int ref_div(input int k);
      int i, j, dx, dy;
      i = k / COLS;
      j = k % COLS;
      if (j == 0)             dx = px_mem[k];
      else if (j == COLS - 1) dx = -int'(px_mem[k-1]);
      else                    dx = px_mem[k] - px_mem[k-1];
      if (i == 0)             dy = py_mem[k];
      else if (i == ROWS - 1) dy = -int'(py_mem[k-COLS]);
      else                    dy = py_mem[k] - py_mem[k-COLS];
      return dx + dy;
   endfunction

   task automatic fill(input int mode);
      for (int k = 0; k < NPIX; k++) begin
         case (mode)
            0: begin px_mem[k] = 8'sd1; py_mem[k] = 8'sd0; end
            1: begin px_mem[k] = 8'(k % COLS); py_mem[k] = 8'sd0; end
            2: begin px_mem[k] = 8'sd0; py_mem[k] = 8'sd2; end
            3: begin
               px_mem[k] = (k % COLS == 0) ? -8'sd128 : ((k % COLS == 1) ? 8'sd127 : 8'sd0);
               py_mem[k] = (k / COLS == 0) ? -8'sd128 : ((k / COLS == 1) ? 8'sd127 : 8'sd0);
            end
            default: begin px_mem[k] = 8'($urandom); py_mem[k] = 8'($urandom); end
         endcase
      end
   endtask

   task automatic run_frame(input bit spam, input int rst_at);
      int n = 0;
      int cyc = 0;
      logic signed [WIDTH+1:0] d;
      @(negedge clk);
      bus.i_start = 1'b1;
      @(negedge clk);
      if (!spam) bus.i_start = 1'b0;
      check("busy_after_start", 32'(bus.o_busy), 32'sd1);
      while (n < NPIX && cyc < NPIX + 20) begin
         if (cyc < NPIX) check("rd_addr", 32'(bus.o_rd_addr), 32'(cyc));
         if (n > 0) check("valid_contig", 32'(bus.o_valid), 32'sd1);
         if (bus.o_valid) begin
            if (n == 0) check("latency", 32'(cyc), 32'sd2);
            d = bus.o_data;
            got[n] = 32'(d);
            check("busy_in_frame", 32'(bus.o_busy), 32'sd1);
            check("wr_addr", 32'(bus.o_wr_addr), 32'(n));
            check("data", 32'(d), 32'(ref_div(n)));
            if (n == rst_at) begin
               rst = 1'b1;
               bus.i_start = 1'b0;
               @(negedge clk);
               check("valid_after_reset", 32'(bus.o_valid), 32'sd0);
               check("busy_after_reset", 32'(bus.o_busy), 32'sd0);
               rst = 1'b0;
               return;
            end
            n++;
         end
         cyc++;
         @(negedge clk);
      end
      bus.i_start = 1'b0;
      check("valid_count", 32'(n), 32'(NPIX));
      check("busy_end", 32'(bus.o_busy), 32'sd0);
      check("valid_end", 32'(bus.o_valid), 32'sd0);
      repeat (3) begin
         @(negedge clk);
         check("idle_valid", 32'(bus.o_valid), 32'sd0);
         check("idle_busy", 32'(bus.o_busy), 32'sd0);
      end
   endtask

   initial begin
      bus.i_start = 1'b0;
      fill(0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(bus.o_valid), 32'sd0);
      check("rst_busy", 32'(bus.o_busy), 32'sd0);
      check("rst_rd_addr", 32'(bus.o_rd_addr), 32'sd0);
      check("rst_wr_addr", 32'(bus.o_wr_addr), 32'sd0);
      check("rst_data", 32'(bus.o_data), 32'sd0);
      rst = 1'b0;

      for (int m = 0; m < 4; m++) begin
         fill(m);
         run_frame(1'b0, -1);
         if (m == 0) check("row_pattern_px1", 32'(got[7]), -32'sd1);
         if (m == 1) check("row_pattern_pxj", 32'(got[3]), -32'sd2);
         if (m == 2) check("col_pattern_py2", 32'(got[13]), -32'sd2);
      end
      check("corner_min", 32'(got[0]), -32'sd256);
      check("corner_max", 32'(got[5]), 32'sd510);

      fill(4);
      run_frame(1'b1, -1);

      // Reset and start in the same cycle: reset wins.
      @(negedge clk);
      rst = 1'b1;
      bus.i_start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.i_start = 1'b0;
      check("reset_wins_busy", 32'(bus.o_busy), 32'sd0);
      @(negedge clk);
      check("reset_wins_valid", 32'(bus.o_valid), 32'sd0);

      fill(4);
      run_frame(1'b0, 5);
      run_frame(1'b0, -1);

      for (int r = 0; r < 3; r++) begin
         fill(4);
         run_frame(1'b0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
